asic_bringup_seq: RTL and testbench

//  FPGA-side bring-up sequencer for the ASIC under test. Debounces the board push-buttons,

---
 rtl/asic_bringup_pkg.sv | 29 ++
 rtl/asic_bringup_seq_if.sv | 24 ++
 rtl/asic_bringup_seq_btn_debounce.sv | 31 +++
 rtl/asic_bringup_seq.sv | 100 ++++++++++
 tb/tb_asic_bringup_seq.sv | 319 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/asic_bringup_pkg.sv
// Shared types and width helpers for the ASIC bring-up sequencer.
package asic_bringup_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      RST    = 3'd1,
      HOLD   = 3'd2,
      SETUP  = 3'd3,
      CLKOFF = 3'd4,
      CLK_ON = 3'd5,
      RUN    = 3'd6,
      ERR    = 3'd7
   } state_t;

   // Debounce counter must hold DEB_CYC itself (the saturation value).
   function automatic int deb_w(input int deb_cyc);
      return $clog2(deb_cyc) + 1;
   endfunction

   // One timer shared by every timed state, sized for the longest interval.
   function automatic int tmr_w(input int rst_cyc, input int setup_cyc, input int lock_to);
      int m;
      m = rst_cyc;
      if (setup_cyc > m) m = setup_cyc;
      if (lock_to > m) m = lock_to;
      return $clog2(m) + 1;
   endfunction

endpackage

// File: rtl/asic_bringup_seq_if.sv
// Button, lock and ASIC-control signals of the bring-up sequencer.
interface asic_bringup_seq_if;

   logic       I_SW_S;
   logic       I_SW_C;
   logic       I_SW_N;
   logic       I_DLL_lock;
   logic       O_reset_n;
   logic       O_SW_clk;
   logic       O_ready;
   logic       O_err;
   logic [2:0] O_state;

   modport master (
      output I_SW_S, I_SW_C, I_SW_N, I_DLL_lock,
      input  O_reset_n, O_SW_clk, O_ready, O_err, O_state
   );

   modport slave (
      input  I_SW_S, I_SW_C, I_SW_N, I_DLL_lock,
      output O_reset_n, O_SW_clk, O_ready, O_err, O_state
   );

endinterface

// File: rtl/asic_bringup_seq_btn_debounce.sv
// Push-button debouncer: one registered pulse per press held DEB_CYC cycles.
module btn_debounce
   import asic_bringup_pkg::*;
#(
   parameter int DEB_CYC = 200
) (
   input  logic I_clk,
   input  logic I_rst,
   input  logic I_btn,
   output logic O_pulse
);

   localparam int W = deb_w(DEB_CYC);

   logic [W-1:0] cnt;

   // Count consecutive high cycles; parking at DEB_CYC keeps a held button from re-firing
   always_ff @(posedge I_clk) begin
      if (I_rst) begin
         cnt     <= '0;
         O_pulse <= 1'b0;
      end else begin
         O_pulse <= I_btn && (cnt == W'(DEB_CYC - 1));
         if (!I_btn)
            cnt <= '0;
         else if (cnt != W'(DEB_CYC))
            cnt <= cnt + W'(1);
      end
   end

endmodule

// File: rtl/asic_bringup_seq.sv
// ASIC bring-up sequencer: reset sequencing, core-clock gating, DLL lock supervision.
module asic_bringup_seq
   import asic_bringup_pkg::*;
#(
   parameter int DEB_CYC    = 200,
   parameter int RST_CYC    = 64,
   parameter int SETUP_CYC  = 16,
   parameter int LOCK_TO    = 4096,
   parameter bit AUTO_REL   = 1'b1,
   parameter bit BYPASS_DLL = 1'b0
) (
   input  logic              I_clk,
   input  logic              I_rst,
   asic_bringup_seq_if.slave bus
);

   localparam int TW = tmr_w(RST_CYC, SETUP_CYC, LOCK_TO);

   logic          sw_s, sw_c, sw_n;
   logic          lock_m, lock_s;
   state_t        state, nxt;
   logic [TW-1:0] timer;
   logic          rst_n_d, sw_clk_d, ready_d, err_d;

   btn_debounce #(.DEB_CYC(DEB_CYC)) u_deb_s (
      .I_clk(I_clk), .I_rst(I_rst), .I_btn(bus.I_SW_S), .O_pulse(sw_s));
   btn_debounce #(.DEB_CYC(DEB_CYC)) u_deb_c (
      .I_clk(I_clk), .I_rst(I_rst), .I_btn(bus.I_SW_C), .O_pulse(sw_c));
   btn_debounce #(.DEB_CYC(DEB_CYC)) u_deb_n (
      .I_clk(I_clk), .I_rst(I_rst), .I_btn(bus.I_SW_N), .O_pulse(sw_n));

   // Two-flop synchroniser for the DLL lock, which is asynchronous to I_clk
   always_ff @(posedge I_clk) begin
      if (I_rst) begin
         lock_m <= 1'b0;
         lock_s <= 1'b0;
      end else begin
         lock_m <= bus.I_DLL_lock;
         lock_s <= lock_m;
      end
   end

   // State, shared timer and outputs; the timer restarts on any entry, including RST re-entry
   always_ff @(posedge I_clk) begin
      if (I_rst) begin
         state         <= IDLE;
         timer         <= '0;
         bus.O_reset_n <= 1'b0;
         bus.O_SW_clk  <= 1'b0;
         bus.O_ready   <= 1'b0;
         bus.O_err     <= 1'b0;
      end else begin
         state <= nxt;
         if (nxt != state || sw_s)
            timer <= '0;
         else if (timer != '1)
            timer <= timer + TW'(1);
         bus.O_reset_n <= rst_n_d;
         bus.O_SW_clk  <= sw_clk_d;
         bus.O_ready   <= ready_d;
         bus.O_err     <= err_d;
      end
   end

   assign bus.O_state = state;

   // Next-state logic; SW_S restarts from any state, SW_N beats lock events
   always_comb begin
      nxt = state;
      if (sw_s) begin
         nxt = RST;
      end else begin
         case (state)
            IDLE, ERR: nxt = state;
            RST:    if (timer == TW'(RST_CYC - 1)) nxt = AUTO_REL ? SETUP : HOLD;
            HOLD:   if (sw_c) nxt = SETUP;
            SETUP:  if (timer == TW'(SETUP_CYC - 1)) nxt = CLKOFF;
            CLKOFF: if (sw_n) nxt = CLK_ON;
            CLK_ON: begin
               if (sw_n)                       nxt = CLKOFF;
               else if (BYPASS_DLL || lock_s)  nxt = RUN;
               else if (timer == TW'(LOCK_TO - 1)) nxt = ERR;
            end
            RUN: begin
               if (sw_n)                       nxt = CLKOFF;
               else if (!BYPASS_DLL && !lock_s) nxt = ERR;
            end
         endcase
      end
   end

   // Output decode from the next state so outputs switch on the same edge as the state
   always_comb begin
      rst_n_d  = nxt inside {SETUP, CLKOFF, CLK_ON, RUN};
      sw_clk_d = nxt inside {CLK_ON, RUN};
      ready_d  = (nxt == RUN);
      err_d    = (nxt == ERR);
   end

endmodule

// File: tb/tb_asic_bringup_seq.sv
// Bench for asic_bringup_seq: auto-release and manual/bypass instances on shared stimulus.
module tb_asic_bringup_seq;
   import asic_bringup_pkg::*;

   localparam int DEB  = 200;
   localparam int RSTC = 64;
   localparam int SETC = 16;
   localparam int LTO  = 4096;
   localparam logic [2:0] BS = 3'b001, BC = 3'b010, BN = 3'b100;

   typedef struct packed {
      logic [2:0] st;
      logic       rn, ck, rd, er;
   } vec_t;

   typedef struct {
      vec_t        v;
      int unsigned cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic s = 1'b0, c = 1'b0, n = 1'b0, lk = 1'b0;
   bit   mon_en = 1'b0;
   int   checks = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   asic_bringup_seq_if bus_a ();
   asic_bringup_seq_if bus_m ();

   assign bus_a.I_SW_S = s;  assign bus_m.I_SW_S = s;
   assign bus_a.I_SW_C = c;  assign bus_m.I_SW_C = c;
   assign bus_a.I_SW_N = n;  assign bus_m.I_SW_N = n;
   assign bus_a.I_DLL_lock = lk;  assign bus_m.I_DLL_lock = lk;

   asic_bringup_seq #(.DEB_CYC(DEB), .RST_CYC(RSTC), .SETUP_CYC(SETC), .LOCK_TO(LTO),
                      .AUTO_REL(1'b1), .BYPASS_DLL(1'b0))
      dut_a (.I_clk(clk), .I_rst(rst), .bus(bus_a));

   asic_bringup_seq #(.DEB_CYC(DEB), .RST_CYC(RSTC), .SETUP_CYC(SETC), .LOCK_TO(LTO),
                      .AUTO_REL(1'b0), .BYPASS_DLL(1'b1))
      dut_m (.I_clk(clk), .I_rst(rst), .bus(bus_m));

   // ---------------- reference model ----------------
   int unsigned cyc = 0;
   int unsigned hcnt[3];
   bit          pend[3];
   bit          lk_d1, lk_d2;
   state_t      m_st[2];
   int unsigned m_entry[2];
   vec_t        m_last[2] = '{7'd0, 7'd0};
   vec_t        m_prev[2] = '{7'd0, 7'd0};
   bit          auto_rel[2] = '{1'b1, 1'b0};
   bit          bypass[2]   = '{1'b0, 1'b1};
   exp_t        q0[$], q1[$];

   function automatic vec_t expect_vec(input state_t st);
      vec_t v;
      v = '0;
      v.st = st;
      case (st)
         SETUP, CLKOFF: v.rn = 1'b1;
         CLK_ON:        begin v.rn = 1'b1; v.ck = 1'b1; end
         RUN:           begin v.rn = 1'b1; v.ck = 1'b1; v.rd = 1'b1; end
         ERR:           v.er = 1'b1;
         default:       ;
      endcase
      return v;
   endfunction

   function automatic int qsize(input int i);
      return (i == 0) ? q0.size() : q1.size();
   endfunction

   function automatic exp_t qhead(input int i);
      return (i == 0) ? q0[0] : q1[0];
   endfunction

   function automatic void qpop(input int i);
      if (i == 0) void'(q0.pop_front()); else void'(q1.pop_front());
   endfunction

   function automatic void qpush(input int i, input exp_t e);
      if (i == 0) q0.push_back(e); else q1.push_back(e);
   endfunction

   function automatic void step(input int i, input bit ps, input bit pc, input bit pn, input bit lku);
      state_t      st, nx;
      int unsigned age;
      bit          restart;
      st = m_st[i];
      nx = st;
      age = cyc - m_entry[i];
      restart = 1'b0;
      if (ps) begin
         nx = RST;
         restart = 1'b1;
      end else begin
         case (st)
            RST:    if (age == RSTC) nx = auto_rel[i] ? SETUP : HOLD;
            HOLD:   if (pc) nx = SETUP;
            SETUP:  if (age == SETC) nx = CLKOFF;
            CLKOFF: if (pn) nx = CLK_ON;
            CLK_ON: begin
               if (pn)                    nx = CLKOFF;
               else if (bypass[i] || lku) nx = RUN;
               else if (age == LTO)       nx = ERR;
            end
            RUN: begin
               if (pn)                      nx = CLKOFF;
               else if (!bypass[i] && !lku) nx = ERR;
            end
            default: ;
         endcase
      end
      if (restart || nx != st) m_entry[i] = cyc;
      m_st[i] = nx;
   endfunction

   always @(posedge clk) begin : model
      bit   ps, pc, pn, lku;
      bit   bin[3];
      vec_t v;
      exp_t e;
      cyc++;
      if (rst) begin
         for (int b = 0; b < 3; b++) begin hcnt[b] = 0; pend[b] = 1'b0; end
         lk_d1 = 1'b0;
         lk_d2 = 1'b0;
         for (int i = 0; i < 2; i++) begin m_st[i] = IDLE; m_entry[i] = cyc; end
      end else begin
         ps = pend[0]; pc = pend[1]; pn = pend[2];
         lku = lk_d2;
         lk_d2 = lk_d1;
         lk_d1 = lk;
         bin[0] = s; bin[1] = c; bin[2] = n;
         for (int b = 0; b < 3; b++) begin
            if (bin[b]) hcnt[b]++; else hcnt[b] = 0;
            pend[b] = bin[b] && (hcnt[b] == DEB);
         end
         for (int i = 0; i < 2; i++) step(i, ps, pc, pn, lku);
      end
      for (int i = 0; i < 2; i++) begin
         v = expect_vec(m_st[i]);
         if (v != m_last[i]) begin
            e.v = v;
            e.cyc = cyc;
            qpush(i, e);
            m_last[i] = v;
         end
      end
   end

   // ---------------- monitor / scoreboard ----------------
   task automatic mon_one(input int i, input vec_t cur);
      exp_t e;
      if (cur !== m_prev[i]) begin
         checks++;
         if (qsize(i) == 0) begin
            failures++;
            $display("FAIL unexpected_change[%0d] cyc=%0d got=%07b required=%07b", i, cyc, cur, m_prev[i]);
         end else begin
            e = qhead(i);
            if (e.cyc != cyc) begin
               failures++;
               $display("FAIL early_change[%0d] cyc=%0d got=%07b required=%07b (due cyc %0d)",
                        i, cyc, cur, m_prev[i], e.cyc);
            end else begin
               qpop(i);
               if (cur !== e.v) begin
                  failures++;
                  $display("FAIL transition[%0d] cyc=%0d got=%07b required=%07b", i, cyc, cur, e.v);
               end
            end
         end
         m_prev[i] = cur;
      end
      while (qsize(i) != 0) begin
         e = qhead(i);
         if (e.cyc >= cyc) break;
         qpop(i);
         checks++;
         failures++;
         $display("FAIL missed_transition[%0d] cyc=%0d got=%07b required=%07b", i, e.cyc, cur, e.v);
      end
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         mon_one(0, {bus_a.O_state, bus_a.O_reset_n, bus_a.O_SW_clk, bus_a.O_ready, bus_a.O_err});
         mon_one(1, {bus_m.O_state, bus_m.O_reset_n, bus_m.O_SW_clk, bus_m.O_ready, bus_m.O_err});
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic run(input int unsigned ncyc);
      repeat (ncyc) @(negedge clk);
   endtask

   task automatic press(input logic [2:0] mask, input int unsigned len);
      {n, c, s} = mask;
      run(len);
      {n, c, s} = 3'b000;
   endtask

   task automatic spot(input string nm);
      vec_t cur[2];
      vec_t want;
      cur[0] = {bus_a.O_state, bus_a.O_reset_n, bus_a.O_SW_clk, bus_a.O_ready, bus_a.O_err};
      cur[1] = {bus_m.O_state, bus_m.O_reset_n, bus_m.O_SW_clk, bus_m.O_ready, bus_m.O_err};
      for (int i = 0; i < 2; i++) begin
         want = expect_vec(m_st[i]);
         checks++;
         if (cur[i] !== want) begin
            failures++;
            $display("FAIL %s[%0d] cyc=%0d got=%07b required=%07b", nm, i, cyc, cur[i], want);
         end
      end
   endtask

   task automatic reset_check(input string nm);
      vec_t cur[2];
      cur[0] = {bus_a.O_state, bus_a.O_reset_n, bus_a.O_SW_clk, bus_a.O_ready, bus_a.O_err};
      cur[1] = {bus_m.O_state, bus_m.O_reset_n, bus_m.O_SW_clk, bus_m.O_ready, bus_m.O_err};
      for (int i = 0; i < 2; i++) begin
         checks++;
         if (cur[i] !== 7'b0) begin
            failures++;
            $display("FAIL %s[%0d] cyc=%0d got=%07b required=0000000", nm, i, cyc, cur[i]);
         end
      end
   endtask

   // SW_N press whose debounced pulse lands on the same edge as a one-cycle lock loss
   task automatic sw_n_with_lock_drop();
      n = 1'b1;
      for (int k = 1; k <= DEB; k++) begin
         lk = (k != DEB - 1);
         @(negedge clk);
      end
      n = 1'b0;
      lk = 1'b1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog cyc=%0d got=running required=finished", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      run(4);
      reset_check("reset_state");
      rst = 1'b0;
      mon_en = 1'b1;

      press(BS, $urandom_range(100, DEB - 1)); run(5); spot("short_press");
      press(BS, DEB); run(10); spot("rst_entered");
      run(40);  spot("rst_hold");
      run(60);  spot("setup_done");

      lk = 1'b1;
      press(BN, $urandom_range(DEB, DEB + 20)); run(5); spot("run_locked");
      press(BC, DEB); run(30); spot("manual_release");
      press(BN, DEB); run(5);  spot("gate_toggle");

      lk = 1'b0; run(3);
      press(BN, DEB); run(LTO + 10); spot("lock_timeout");
      press(BS, DEB); run(5); spot("err_restart");
      run(100); lk = 1'b1;
      press(BC, DEB); run(20);
      press(BN, DEB); run(10); spot("both_run");
      lk = 1'b0; run(1); lk = 1'b1; run(5); spot("lock_glitch");

      press(BS, DEB); run(90); press(BC, DEB); run(20); press(BN, DEB); run(10); spot("rerun");
      sw_n_with_lock_drop(); run(5); spot("sw_n_beats_lock_loss");

      press(BS, DEB); run(70); spot("auto_setup");
      press(BC, DEB); run(3); spot("manual_setup");
      rst = 1'b1; run(2); reset_check("mid_setup_reset"); rst = 1'b0; run(2); spot("after_reset");

      for (int it = 0; it < 40; it++) begin
         case ($urandom_range(0, 9))
            0, 1, 2, 3: press(3'($urandom_range(1, 7)), $urandom_range(150, 260));
            4, 5:       begin lk = ~lk; run($urandom_range(1, 40)); end
            6:          begin lk = 1'b0; run(1); lk = 1'b1; run($urandom_range(1, 10)); end
            7:          run($urandom_range(1, 300));
            8: begin
               if ($urandom_range(0, 3) == 0) begin
                  rst = 1'b1; run($urandom_range(1, 3)); rst = 1'b0;
               end else begin
                  lk = 1'b0; run($urandom_range(LTO - 50, LTO + 50));
               end
            end
            default: sw_n_with_lock_drop();
         endcase
         run(3);
         spot("random");
      end

      run(5);
      while (q0.size() != 0 || q1.size() != 0) begin
         checks++;
         failures++;
         if (q0.size() != 0) begin
            $display("FAIL leftover[0] got=none required=%07b at cyc %0d", q0[0].v, q0[0].cyc);
            void'(q0.pop_front());
         end else begin
            $display("FAIL leftover[1] got=none required=%07b at cyc %0d", q1[0].v, q1[0].cyc);
            void'(q1.pop_front());
         end
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
